// File: rtl/match_sequencer.sv
// match_sequencer: gates serves, converts toggle goal flags to scores, declares the winner
//   clk, reset (sync, active-high), start_btn (rising edge starts a match),
//   blue_score_up/red_score_up (toggle per goal), game_initiated (launch pulse),
//   game_over (ball held dead), blue_score/red_score, winner, state_out
module match_sequencer #(
  parameter int SERVE_DELAY = 50_000_000,
  parameter int WIN_SCORE = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start_btn,
  input  logic       blue_score_up,
  input  logic       red_score_up,
  output logic       game_initiated,
  output logic       game_over,
  output logic [3:0] blue_score,
  output logic [3:0] red_score,
  output logic [1:0] winner,
  output logic [1:0] state_out
);
  typedef enum logic [1:0] {IDLE, SERVE, LIVE, OVER} state_t;
  state_t state;
  logic start_prev, blue_prev, red_prev;
  logic [31:0] serve_cnt;
  logic start_rise, blue_goal, red_goal, blue_win, red_win;
  logic [3:0] blue_next, red_next;
  always_comb begin
    start_rise = start_btn & ~start_prev;
    blue_goal = blue_score_up ^ blue_prev;
    red_goal = red_score_up ^ red_prev;
    blue_next = blue_score + {3'b0, blue_goal};
    red_next = red_score + {3'b0, red_goal};
    blue_win = blue_next == 4'(WIN_SCORE);
    red_win = red_next == 4'(WIN_SCORE);
  end
  assign state_out = state;
  // Prev registers track inputs even in reset so levels present at reset never count as events.
  always_ff @(posedge clk) begin
    start_prev <= start_btn;
    blue_prev <= blue_score_up;
    red_prev <= red_score_up;
    game_initiated <= 1'b0;
    if (reset) begin
      state <= IDLE;
      game_over <= 1'b1;
      blue_score <= '0;
      red_score <= '0;
      winner <= 2'b00;
      serve_cnt <= '0;
    end else begin
      case (state)
        IDLE, OVER: if (start_rise) begin
          state <= SERVE;
          game_over <= 1'b0;
          blue_score <= '0;
          red_score <= '0;
          winner <= 2'b00;
          serve_cnt <= '0;
        end
        SERVE: if (serve_cnt == 32'(SERVE_DELAY - 1)) begin
          state <= LIVE;
          game_initiated <= 1'b1;
          serve_cnt <= '0;
        end else serve_cnt <= serve_cnt + 32'd1;
        LIVE: begin
          // Scores are below WIN_SCORE while LIVE, so a single increment saturates at WIN_SCORE.
          blue_score <= blue_next;
          red_score <= red_next;
          if (blue_win || red_win) begin
            state <= OVER;
            game_over <= 1'b1;
            winner <= {red_win, blue_win};
          end else if (blue_goal || red_goal) state <= SERVE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_match_sequencer.sv
// tb_match_sequencer: random stimulus checked against a behavioural match model
module tb_match_sequencer;
  localparam int SD = 4;
  localparam int WS = 3;
  logic clk = 1'b0;
  logic reset, start_btn, blue_score_up, red_score_up;
  logic game_initiated, game_over;
  logic [3:0] blue_score, red_score;
  logic [1:0] winner, state_out;
  int total = 0;
  int bad = 0;
  match_sequencer #(.SERVE_DELAY(SD), .WIN_SCORE(WS)) dut (
    .clk(clk), .reset(reset), .start_btn(start_btn), .blue_score_up(blue_score_up),
    .red_score_up(red_score_up), .game_initiated(game_initiated), .game_over(game_over),
    .blue_score(blue_score), .red_score(red_score), .winner(winner), .state_out(state_out)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, got, exp);
    end
  endtask
  // model: phase 0 idle, 1 serving, 2 live, 3 over
  int m_phase, m_wait, m_blue, m_red, m_win, m_go, m_gi;
  bit p_start, p_blue, p_red;
  initial begin
    int r;
    bit rise, bg, rg;
    reset = 1'b1;
    start_btn = 1'b0;
    blue_score_up = 1'b1;
    red_score_up = 1'b0;
    for (int cyc = 0; cyc < 6000; cyc++) begin
      @(negedge clk);
      reset = (cyc < 3) || ($urandom_range(149) == 0);
      if ($urandom_range(5) == 0) start_btn = ~start_btn;
      r = $urandom_range(9);
      if (r == 0 || r == 2) blue_score_up = ~blue_score_up;
      if (r == 1 || r == 2) red_score_up = ~red_score_up;
      @(posedge clk);
      m_gi = 0;
      if (reset) begin
        m_phase = 0; m_go = 1; m_blue = 0; m_red = 0; m_win = 0; m_wait = 0;
      end else begin
        rise = start_btn && !p_start;
        bg = blue_score_up != p_blue;
        rg = red_score_up != p_red;
        if ((m_phase == 0 || m_phase == 3) && rise) begin
          m_phase = 1; m_go = 0; m_blue = 0; m_red = 0; m_win = 0; m_wait = 0;
        end else if (m_phase == 1) begin
          m_wait++;
          if (m_wait == SD) begin
            m_phase = 2; m_gi = 1; m_wait = 0;
          end
        end else if (m_phase == 2) begin
          m_blue += int'(bg);
          m_red += int'(rg);
          if (m_blue == WS || m_red == WS) begin
            m_phase = 3; m_go = 1;
            m_win = (m_blue == WS ? 1 : 0) + (m_red == WS ? 2 : 0);
          end else if (bg || rg) m_phase = 1;
        end
      end
      p_start = start_btn;
      p_blue = blue_score_up;
      p_red = red_score_up;
      #1;
      chk("state", state_out, m_phase);
      chk("game_over", game_over, m_go);
      chk("game_initiated", game_initiated, m_gi);
      chk("blue_score", blue_score, m_blue);
      chk("red_score", red_score, m_red);
      chk("winner", winner, m_win);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
